// File: rtl/repeat_nfa_pkg.sv
// Shared constants and element mode encodings for the repeat_nfa_chain matcher.
package repeat_nfa_pkg;

    localparam int unsigned DEFAULT_DEPTH = 8;
    localparam int unsigned DEFAULT_PW    = 8;

    typedef enum logic [1:0] {
        MODE_LIT     = 2'b00,
        MODE_ANY     = 2'b01,
        MODE_REP     = 2'b10,
        MODE_LIT_ALT = 2'b11
    } mode_e;

endpackage

// File: rtl/repeat_nfa_elem.sv
// One NFA element: programmable char/mode plus its active flop.
// REPEAT_NFA_MATCH_CNT_EN additionally exports the pre-edge next-state of act.
module repeat_nfa_elem
    import repeat_nfa_pkg::*;
#(
    parameter int unsigned PW = DEFAULT_PW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr,
    input  logic          clr,
    input  logic          adv,
    input  logic [PW-1:0] cfg_char,
    input  logic [1:0]    cfg_mode,
    input  logic [PW-1:0] payload,
    input  logic          prev_act,
    output logic          act
`ifdef REPEAT_NFA_MATCH_CNT_EN
    ,
    output logic          act_nxt
`endif
);

    logic [PW-1:0] chr;
    mode_e         mode;
    logic          hit;
    logic          act_d;

    assign hit = (mode == MODE_ANY) || (payload == chr);

    // A repeat element may keep itself alive; every element needs a hit on this byte.
    always_comb begin
        act_d = act;
        if (clr) begin
            act_d = 1'b0;
        end else if (adv) begin
            act_d = (prev_act || ((mode == MODE_REP) && act)) && hit;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chr  <= '0;
            mode <= MODE_LIT;
            act  <= 1'b0;
        end else begin
            act <= act_d;
            if (wr) begin
                chr  <= cfg_char;
                mode <= mode_e'(cfg_mode);
            end
        end
    end

`ifdef REPEAT_NFA_MATCH_CNT_EN
    assign act_nxt = act_d;
`endif

endmodule

// File: rtl/repeat_nfa_chain.sv
// Chain of DEPTH NFA elements matching a programmable pattern with repeat/any-char.
// REPEAT_NFA_MATCH_CNT_EN adds cnt_clr and a saturating 16-bit match_cnt.
module repeat_nfa_chain
    import repeat_nfa_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned PW    = DEFAULT_PW
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic                       payload_valid,
    input  logic [PW-1:0]              payload,
    input  logic                       cfg_we,
    input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
    input  logic [PW-1:0]              cfg_char,
    input  logic [1:0]                 cfg_mode,
    input  logic [$clog2(DEPTH):0]     cfg_len,
`ifdef REPEAT_NFA_MATCH_CNT_EN
    input  logic                       cnt_clr,
    output logic [15:0]                match_cnt,
`endif
    output logic                       match
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [DEPTH-1:0] act;
`ifdef REPEAT_NFA_MATCH_CNT_EN
    logic [DEPTH-1:0] act_nxt;
    logic             match_nxt;
`endif

    for (genvar k = 0; k < DEPTH; k++) begin : g_elem
        logic prev;
        if (k == 0) begin : g_head
            assign prev = en;
        end else begin : g_link
            assign prev = act[k-1];
        end

        repeat_nfa_elem #(.PW(PW)) u_elem (
            .clk      (clk),
            .reset_n  (reset_n),
            .wr       (cfg_we && (cfg_addr == AW'(k))),
            .clr      (cfg_we),
            .adv      (payload_valid),
            .cfg_char (cfg_char),
            .cfg_mode (cfg_mode),
            .payload  (payload),
            .prev_act (prev),
            .act      (act[k])
`ifdef REPEAT_NFA_MATCH_CNT_EN
            ,
            .act_nxt  (act_nxt[k])
`endif
        );
    end

    // Out-of-range lengths (0 or > DEPTH) never equal any i+1, so match stays 0.
    always_comb begin
        match = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (cfg_len == LW'(i + 1)) match = act[i];
        end
    end

`ifdef REPEAT_NFA_MATCH_CNT_EN
    always_comb begin
        match_nxt = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (cfg_len == LW'(i + 1)) match_nxt = act_nxt[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
        end else if (match_nxt && (match_cnt != '1)) begin
            match_cnt <= match_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_repeat_nfa_chain.sv
// Self-checking bench for repeat_nfa_chain: directed scenarios plus randomized streams
// checked against a per-start-position pattern matcher over the recorded byte history.
module tb_repeat_nfa_chain;
    import repeat_nfa_pkg::*;

    localparam int unsigned DEPTH = DEFAULT_DEPTH;
    localparam int unsigned PW    = DEFAULT_PW;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LW    = AW + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b0;
    logic          payload_valid = 1'b0;
    logic [PW-1:0] payload = '0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [PW-1:0] cfg_char = '0;
    logic [1:0]    cfg_mode = '0;
    logic [LW-1:0] cfg_len = '0;
    logic          match;
`ifdef REPEAT_NFA_MATCH_CNT_EN
    logic          cnt_clr = 1'b0;
    logic [15:0]   match_cnt;
`endif

    int vectors = 0;
    int errors  = 0;

    // reference model state: programmed pattern and bytes accepted since last clear
    logic [PW-1:0] m_char [DEPTH];
    logic [1:0]    m_mode [DEPTH];
    logic [PW-1:0] hist_b [$];
    logic          hist_e [$];

    always #5 clk = ~clk;

    repeat_nfa_chain #(.DEPTH(DEPTH), .PW(PW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .en            (en),
        .payload_valid (payload_valid),
        .payload       (payload),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_char      (cfg_char),
        .cfg_mode      (cfg_mode),
        .cfg_len       (cfg_len),
`ifdef REPEAT_NFA_MATCH_CNT_EN
        .cnt_clr       (cnt_clr),
        .match_cnt     (match_cnt),
`endif
        .match         (match)
    );

    function automatic logic m_hit(int unsigned i, logic [PW-1:0] c);
        return (m_mode[i] == 2'b01) || (c == m_char[i]);
    endfunction

    // Pattern ends on the latest byte if some start byte (with en) begins a run through element len-1.
    function automatic logic model_match(int unsigned len);
        logic [DEPTH-1:0] s;
        logic [DEPTH-1:0] n;
        logic             from_prev;
        if (len == 0 || len > DEPTH) return 1'b0;
        for (int st = 0; st < hist_b.size(); st++) begin
            if (!hist_e[st]) continue;
            s = '0;
            for (int t = st; t < hist_b.size(); t++) begin
                n = '0;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (i == 0) from_prev = (t == st);
                    else        from_prev = s[i-1];
                    n[i] = m_hit(i, hist_b[t]) && (from_prev || ((m_mode[i] == 2'b10) && s[i]));
                end
                s = n;
                if (s == '0) break;
            end
            if (s[len-1]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_reset();
        for (int unsigned i = 0; i < DEPTH; i++) begin
            m_char[i] = '0;
            m_mode[i] = 2'b00;
        end
        hist_b.delete();
        hist_e.delete();
    endfunction

    task automatic apply(input logic v, input logic [PW-1:0] b, input logic e,
                         output logic obs, output logic exp);
        payload_valid = v;
        payload       = b;
        en            = e;
        @(posedge clk);
        #1;
        if (v) begin
            hist_b.push_back(b);
            hist_e.push_back(e);
        end
        payload_valid = 1'b0;
        obs = match;
        exp = model_match(int'(cfg_len));
    endtask

    // payload_valid is held high with a hitting byte to exercise cfg_we priority
    task automatic write_elem(input int unsigned a, input logic [PW-1:0] c, input logic [1:0] m);
        cfg_we        = 1'b1;
        cfg_addr      = AW'(a);
        cfg_char      = c;
        cfg_mode      = m;
        payload_valid = 1'b1;
        payload       = c;
        en            = 1'b1;
        @(posedge clk);
        #1;
        cfg_we        = 1'b0;
        payload_valid = 1'b0;
        m_char[a]     = c;
        m_mode[a]     = m;
        hist_b.delete();
        hist_e.delete();
        vectors++;
        if (match !== 1'b0) begin
            errors++;
            $display("FAIL cfg_we_clear: got %0b expected 0", match);
        end
    endtask

    task automatic program3(input logic [PW-1:0] c0, input logic [1:0] m0,
                            input logic [PW-1:0] c1, input logic [1:0] m1,
                            input logic [PW-1:0] c2, input logic [1:0] m2);
        write_elem(0, c0, m0);
        write_elem(1, c1, m1);
        write_elem(2, c2, m2);
        cfg_len = LW'(3);
    endtask

    task automatic test_reset();
        logic obs, exp;
        reset_n = 1'b0;
        #3;
        vectors++;
        if (match !== 1'b0) begin
            errors++;
            $display("FAIL reset_match: got %0b expected 0", match);
        end
`ifdef REPEAT_NFA_MATCH_CNT_EN
        vectors++;
        if (match_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_cnt: got %h expected 0000", match_cnt);
        end
`endif
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
        // reset pattern is literal 0x00: 0x05 must miss, 0x00 must hit
        cfg_len = LW'(1);
        apply(1'b1, 8'h05, 1'b1, obs, exp);
        vectors++;
        if (obs !== 1'b0) begin
            errors++;
            $display("FAIL reset_mode_lit: got %0b expected 0", obs);
        end
        apply(1'b1, 8'h00, 1'b1, obs, exp);
        vectors++;
        if (obs !== 1'b1) begin
            errors++;
            $display("FAIL reset_char_zero: got %0b expected 1", obs);
        end
    endtask

    task automatic test_literal();
        logic [PW-1:0] str [6];
        logic          want [6];
        logic          obs, exp;
        program3("a", 2'b00, "b", 2'b00, "c", 2'b00);
        str  = '{"x", "a", "b", "c", "a", "b"};
        want = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, str[i], 1'b1, obs, exp);
            vectors++;
            if (obs !== want[i]) begin
                errors++;
                $display("FAIL literal_abc[%0d]: got %0b expected %0b", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_repeat();
        logic [PW-1:0] str [7];
        logic          want [7];
        logic          obs, exp;
        program3("a", 2'b00, "b", 2'b10, "c", 2'b00);
        str  = '{"a", "b", "b", "b", "c", "a", "c"};
        want = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            apply(1'b1, str[i], 1'b1, obs, exp);
            vectors++;
            if (obs !== want[i]) begin
                errors++;
                $display("FAIL repeat_b[%0d]: got %0b expected %0b", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_any();
        logic [PW-1:0] str [6];
        logic          want [6];
        logic          obs, exp;
        program3("a", 2'b00, "q", 2'b01, "c", 2'b00);
        str  = '{"a", "z", "c", "a", "a", "c"};
        want = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, str[i], 1'b1, obs, exp);
            vectors++;
            if (obs !== want[i]) begin
                errors++;
                $display("FAIL any_char[%0d]: got %0b expected %0b", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_gap();
        logic obs, exp;
        program3("a", 2'b00, "b", 2'b00, "c", 2'b00);
        apply(1'b1, "a", 1'b1, obs, exp);
        repeat (3) apply(1'b0, "c", 1'b1, obs, exp);
        apply(1'b1, "b", 1'b1, obs, exp);
        repeat (3) apply(1'b0, "x", 1'b1, obs, exp);
        vectors++;
        if (obs !== 1'b0) begin
            errors++;
            $display("FAIL gap_hold: got %0b expected 0", obs);
        end
        apply(1'b1, "c", 1'b1, obs, exp);
        vectors++;
        if (obs !== 1'b1) begin
            errors++;
            $display("FAIL gap_match: got %0b expected 1", obs);
        end
        // a configuration write mid-pattern throws away the partial match
        apply(1'b1, "a", 1'b1, obs, exp);
        apply(1'b1, "b", 1'b1, obs, exp);
        write_elem(2, "c", 2'b00);
        apply(1'b1, "c", 1'b1, obs, exp);
        vectors++;
        if (obs !== 1'b0) begin
            errors++;
            $display("FAIL cfg_we_abort: got %0b expected 0", obs);
        end
    endtask

    task automatic test_async_reset();
        logic obs, exp;
        program3("a", 2'b00, "b", 2'b00, "c", 2'b00);
        apply(1'b1, "a", 1'b1, obs, exp);
        apply(1'b1, "b", 1'b1, obs, exp);
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (match !== 1'b0) begin
            errors++;
            $display("FAIL midstream_reset_match: got %0b expected 0", match);
        end
`ifdef REPEAT_NFA_MATCH_CNT_EN
        vectors++;
        if (match_cnt !== 16'h0) begin
            errors++;
            $display("FAIL midstream_reset_cnt: got %h expected 0000", match_cnt);
        end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        apply(1'b1, "c", 1'b1, obs, exp);
        vectors++;
        if (obs !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_c: got %0b expected 0", obs);
        end
    endtask

    task automatic test_random();
        logic        obs, exp;
        int unsigned len;
        for (int round = 0; round < 8; round++) begin
            len = $urandom_range(1, DEPTH);
            for (int unsigned i = 0; i < len; i++)
                write_elem(i, PW'(8'h61 + $urandom_range(0, 2)), 2'($urandom_range(0, 3)));
            if (round == 6)      cfg_len = '0;
            else if (round == 7) cfg_len = LW'($urandom_range(DEPTH + 1, (1 << LW) - 1));
            else                 cfg_len = LW'(len);
            for (int step = 0; step < 150; step++) begin
                if ($urandom_range(0, 49) == 0) begin
                    write_elem($urandom_range(0, DEPTH - 1), PW'(8'h61 + $urandom_range(0, 2)),
                               2'($urandom_range(0, 3)));
                end else begin
                    apply($urandom_range(0, 9) < 8, PW'(8'h61 + $urandom_range(0, 3)),
                          $urandom_range(0, 9) < 9, obs, exp);
                    vectors++;
                    if (obs !== exp) begin
                        errors++;
                        $display("FAIL random[r%0d s%0d]: got %0b expected %0b", round, step, obs, exp);
                    end
                end
            end
        end
    endtask

`ifdef REPEAT_NFA_MATCH_CNT_EN
    task automatic test_counter();
        write_elem(0, "a", 2'b01);
        write_elem(1, "a", 2'b01);
        cfg_len       = LW'(2);
        payload_valid = 1'b1;
        en            = 1'b1;
        payload       = "k";
        cnt_clr       = 1'b1;
        repeat (3) @(posedge clk);
        #1 cnt_clr = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (match_cnt !== 16'd5) begin
            errors++;
            $display("FAIL cnt_count5: got %0d expected 5", match_cnt);
        end
        repeat (70000) @(posedge clk);
        #1;
        vectors++;
        if (match_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_saturate: got %h expected ffff", match_cnt);
        end
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr       = 1'b0;
        payload_valid = 1'b0;
        vectors++;
        if (match_cnt !== 16'h0) begin
            errors++;
            $display("FAIL cnt_clear: got %h expected 0000", match_cnt);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_literal();
        test_repeat();
        test_any();
        test_gap();
        test_async_reset();
        test_random();
`ifdef REPEAT_NFA_MATCH_CNT_EN
        test_counter();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
